// File: rtl/rdm_llr_combine.sv
// Rate-dematching combine stage: serializes 16-LLR beats into an Ncb-long circular
// soft buffer, overwriting on the first lap and saturating-accumulating on later laps.
module rdm_llr_combine #(
    parameter int LLR_W   = 6,
    parameter int LLR_NUM = 16,
    parameter int CB_W    = 8,
    parameter int CB_AW   = 16
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rst,
    input  logic                     i_start,
    input  logic [13:0]              i_E_size,
    input  logic [15:0]              i_Ncb_size,
    input  logic [LLR_W*LLR_NUM-1:0] i_llr_data,
    input  logic                     i_llr_valid,
    output logic                     o_llr_ready,
    output logic                     o_cb_rd_en,
    output logic [CB_AW-1:0]         o_cb_rd_addr,
    input  logic [CB_W-1:0]          i_cb_rd_data,
    output logic                     o_cb_wr_en,
    output logic [CB_AW-1:0]         o_cb_wr_addr,
    output logic [CB_W-1:0]          o_cb_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int JW = $clog2(LLR_NUM);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BEAT = 3'd1,
        SERIAL    = 3'd2,
        FLUSH     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [13:0]              e_m1_q;
    logic [CB_AW-1:0]         ncb_m1_q;
    logic [13:0]              n_q;
    logic [CB_AW-1:0]         k_q;
    logic                     lap_q;
    logic [JW-1:0]            j_q;
    logic [LLR_W*LLR_NUM-1:0] beat_q;
    logic                     err_q;
    logic                     wr_en_q;
    logic [CB_AW-1:0]         wr_addr_q;
    logic [LLR_W-1:0]         wr_llr_q;
    logic                     wr_lap_q;

    logic             sizes_ok;
    logic [LLR_W-1:0] cur_llr;
    logic             k_wrap;
    logic             last_llr;

    assign sizes_ok = (i_E_size != 14'd0) && (i_Ncb_size >= 16'd2);
    assign cur_llr  = beat_q[j_q*LLR_W +: LLR_W];
    assign k_wrap   = (k_q == ncb_m1_q);
    assign last_llr = (n_q == e_m1_q);

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_start && sizes_ok) state_d = WAIT_BEAT;
            WAIT_BEAT: if (i_llr_valid) state_d = SERIAL;
            SERIAL: begin
                if (last_llr)                         state_d = FLUSH;
                else if (j_q == JW'(LLR_NUM - 1))     state_d = WAIT_BEAT;
            end
            FLUSH:     state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        o_llr_ready  = (state_q == WAIT_BEAT);
        o_busy       = (state_q != IDLE);
        o_done       = (state_q == DONE);
        o_cb_rd_en   = (state_q == SERIAL) && lap_q;
        o_cb_rd_addr = o_cb_rd_en ? k_q : '0;
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            e_m1_q    <= '0;
            ncb_m1_q  <= '0;
            n_q       <= '0;
            k_q       <= '0;
            lap_q     <= 1'b0;
            j_q       <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_llr_q  <= '0;
            wr_lap_q  <= 1'b0;
        end else begin
            err_q   <= (state_q == IDLE) && i_start && !sizes_ok;
            wr_en_q <= (state_q == SERIAL);
            case (state_q)
                IDLE: if (i_start) begin
                    e_m1_q   <= i_E_size - 14'd1;
                    ncb_m1_q <= CB_AW'(i_Ncb_size - 16'd1);
                    n_q      <= '0;
                    k_q      <= '0;
                    lap_q    <= 1'b0;
                end
                WAIT_BEAT: if (i_llr_valid) begin
                    beat_q <= i_llr_data;
                    j_q    <= '0;
                end
                SERIAL: begin
                    wr_addr_q <= k_q;
                    wr_llr_q  <= cur_llr;
                    wr_lap_q  <= lap_q;
                    n_q       <= n_q + 14'd1;
                    j_q       <= j_q + JW'(1);
                    k_q       <= k_wrap ? '0 : k_q + CB_AW'(1);
                    lap_q     <= lap_q | k_wrap;
                end
                default: ;
            endcase
        end
    end

    assign o_err = err_q;

    // Read data arrives in the write cycle, so accumulate combinationally there.
    logic [CB_W-1:0] sext_llr;
    logic [CB_W:0]   sum;
    logic [CB_W-1:0] sat;

    assign sext_llr = {{(CB_W-LLR_W){wr_llr_q[LLR_W-1]}}, wr_llr_q};
    assign sum      = {i_cb_rd_data[CB_W-1], i_cb_rd_data} + {sext_llr[CB_W-1], sext_llr};

    always_comb begin
        sat = sum[CB_W-1:0];
        if (sum[CB_W] != sum[CB_W-1])
            sat = sum[CB_W] ? {1'b1, {(CB_W-1){1'b0}}} : {1'b0, {(CB_W-1){1'b1}}};
    end

    assign o_cb_wr_en   = wr_en_q;
    assign o_cb_wr_addr = wr_addr_q;
    assign o_cb_wr_data = !wr_en_q ? '0 : (wr_lap_q ? sat : sext_llr);

endmodule

// File: tb/tb_rdm_llr_combine.sv
// Bench for rdm_llr_combine: behavioural combine RAM, write scoreboard fed by a
// reference fold model, and per-scenario tasks for the documented cases.
module tb_rdm_llr_combine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] e_size;
    logic [15:0] ncb_size;
    logic [95:0] llr_data;
    logic        llr_valid;
    logic        llr_ready;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy, done, err;

    rdm_llr_combine dut (
        .i_core_clk(clk), .i_rx_rst(rst), .i_start(start),
        .i_E_size(e_size), .i_Ncb_size(ncb_size),
        .i_llr_data(llr_data), .i_llr_valid(llr_valid), .o_llr_ready(llr_ready),
        .o_cb_rd_en(rd_en), .o_cb_rd_addr(rd_addr), .i_cb_rd_data(rd_data),
        .o_cb_wr_en(wr_en), .o_cb_wr_addr(wr_addr), .o_cb_wr_data(wr_data),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int nwr, nrd, ndone, nacc;
    logic [7:0] mem [256];
    int ref_mem [256];
    int mk, mlap;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[7:0]];
        if (wr_en) mem[wr_addr[7:0]] <= wr_data;
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (llr_valid && llr_ready) nacc++;
        if (rd_en) nrd++;
        if (done) ndone++;
        if (wr_en) begin
            nwr++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected addr=%0d data=%0d", wr_addr, $signed(wr_data));
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    failures++;
                    $display("FAIL wr_seq got addr=%0d data=%0d exp addr=%0d data=%0d",
                             wr_addr, $signed(wr_data), e.a, $signed(e.d));
                end
            end
        end
    end

    function automatic int sat8(int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // Drives one block; lat = cycles from start to o_done, -1 on abort/timeout.
    task automatic run_block(input int E, input int Ncb, input int pat, input int val,
                             input int gap_beat, input int abort_beat, output int lat);
        int nb, c0, t, v, n;
        wr_t w;
        logic [95:0] d;
        lat = -1;
        nb = (E + 15) / 16;
        mk = 0; mlap = 0;
        nwr = 0; nrd = 0; ndone = 0; nacc = 0;
        @(posedge clk); #1;
        e_size = 14'(E); ncb_size = 16'(Ncb); start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int j = 0; j < 16; j++) begin
                v = (pat != 0) ? j - 8 : val;
                d[j*6 +: 6] = 6'(v);
                n = b * 16 + j;
                if (n < E) begin
                    ref_mem[mk] = (mlap != 0) ? sat8(ref_mem[mk] + v) : v;
                    w.a = 16'(mk); w.d = 8'(ref_mem[mk]);
                    exp_q.push_back(w);
                    if (mk == Ncb - 1) begin mk = 0; mlap = 1; end
                    else mk++;
                end
            end
            llr_data = d; llr_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!llr_ready && t < 100) begin t++; @(negedge clk); end
            if (t >= 100) begin
                checks++; failures++;
                $display("FAIL ready_timeout beat=%0d", b);
                llr_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (b == nb - 1) llr_valid = 1'b0;
            if (b == abort_beat - 1) begin
                llr_valid = 1'b0;
                repeat (7) @(posedge clk);
                #1;
                return;
            end
            if (b == gap_beat - 1) begin
                llr_valid = 1'b0;
                t = 0;
                @(negedge clk);
                while (!llr_ready && t < 100) begin t++; @(negedge clk); end
                repeat (5) @(posedge clk);
                #1;
            end
        end
        t = 0;
        @(negedge clk);
        while (!done && t < 400) begin t++; @(negedge clk); end
        if (t >= 400) begin
            checks++; failures++;
            $display("FAIL done_timeout E=%0d Ncb=%0d", E, Ncb);
            return;
        end
        lat = cyc - c0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got busy=%0b done=%0b exp 0 0", busy, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; e_size = '0; ncb_size = '0;
        llr_data = '0; llr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({llr_ready, rd_en, wr_en, busy, done, err} !== 6'b0 ||
            rd_addr !== 16'd0 || wr_addr !== 16'd0 || wr_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b rd=%0b wr=%0b busy=%0b done=%0b err=%0b exp all 0",
                     llr_ready, rd_en, wr_en, busy, done, err);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic check_129(input string tag);
        for (int a = 0; a < 110; a++) begin
            checks++;
            if (mem[a] !== ((a < 19) ? 8'd40 : 8'd20)) begin
                failures++;
                $display("FAIL %s_mem[%0d] got %0d exp %0d", tag, a, $signed(mem[a]), (a < 19) ? 40 : 20);
            end
        end
    endtask

    task automatic test_repeat;
        int lat;
        run_block(129, 110, 0, 20, 0, 0, lat);
        checks++;
        if (nacc !== 9) begin failures++; $display("FAIL rep_beats got %0d exp 9", nacc); end
        checks++;
        if (nwr !== 129) begin failures++; $display("FAIL rep_writes got %0d exp 129", nwr); end
        checks++;
        if (nrd !== 19) begin failures++; $display("FAIL rep_reads got %0d exp 19", nrd); end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL rep_done got %0d exp 1", ndone); end
        checks++;
        if (lat !== 140) begin failures++; $display("FAIL rep_latency got %0d exp 140", lat); end
        check_129("rep");
    endtask

    task automatic test_single_beat;
        int lat;
        run_block(16, 110, 1, 0, 0, 0, lat);
        checks++;
        if (nwr !== 16 || nrd !== 0) begin
            failures++; $display("FAIL single_counts got wr=%0d rd=%0d exp 16 0", nwr, nrd);
        end
        checks++;
        if (lat !== 19) begin failures++; $display("FAIL single_latency got %0d exp 19", lat); end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if ($signed(mem[a]) !== a - 8) begin
                failures++; $display("FAIL single_mem[%0d] got %0d exp %0d", a, $signed(mem[a]), a - 8);
            end
        end
    endtask

    task automatic test_saturate;
        int lat;
        run_block(64, 2, 0, 31, 0, 0, lat);
        checks++;
        if (mem[0] !== 8'd127 || mem[1] !== 8'd127) begin
            failures++; $display("FAIL sat_pos got %0d %0d exp 127 127", $signed(mem[0]), $signed(mem[1]));
        end
        checks++;
        if (nrd !== 62) begin failures++; $display("FAIL sat_reads got %0d exp 62", nrd); end
        run_block(64, 2, 0, -32, 0, 0, lat);
        checks++;
        if (mem[0] !== 8'h80 || mem[1] !== 8'h80) begin
            failures++; $display("FAIL sat_neg got %0d %0d exp -128 -128", $signed(mem[0]), $signed(mem[1]));
        end
    endtask

    task automatic test_err;
        int es [2] = '{0, 20};
        int ns [2] = '{110, 1};
        int saw_rdy;
        for (int i = 0; i < 2; i++) begin
            nwr = 0; ndone = 0; saw_rdy = 0;
            @(posedge clk); #1;
            e_size = 14'(es[i]); ncb_size = 16'(ns[i]); start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL err_pulse case=%0d got err=%0b busy=%0b exp 1 0", i, err, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL err_width case=%0d got %0b exp 0", i, err); end
            repeat (20) begin @(negedge clk); if (llr_ready) saw_rdy++; end
            checks++;
            if (saw_rdy !== 0 || nwr !== 0 || ndone !== 0) begin
                failures++;
                $display("FAIL err_quiet case=%0d got rdy=%0d wr=%0d done=%0d exp 0 0 0", i, saw_rdy, nwr, ndone);
            end
        end
    endtask

    task automatic test_gap;
        int lat;
        run_block(129, 110, 0, 20, 3, 0, lat);
        checks++;
        if (lat !== 145) begin failures++; $display("FAIL gap_latency got %0d exp 145", lat); end
        checks++;
        if (nwr !== 129 || nrd !== 19) begin
            failures++; $display("FAIL gap_counts got wr=%0d rd=%0d exp 129 19", nwr, nrd);
        end
        check_129("gap");
    endtask

    task automatic test_abort;
        int lat, wr_snap;
        run_block(129, 110, 0, 20, 0, 5, lat);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({llr_ready, rd_en, wr_en, busy, done, err} !== 6'b0 || wr_data !== 8'd0) begin
            failures++;
            $display("FAIL abort_outputs got rdy=%0b rd=%0b wr=%0b busy=%0b done=%0b err=%0b exp all 0",
                     llr_ready, rd_en, wr_en, busy, done, err);
        end
        exp_q.delete();
        wr_snap = nwr;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (nwr !== wr_snap || busy !== 1'b0) begin
            failures++; $display("FAIL abort_quiet got wr=%0d busy=%0b exp %0d 0", nwr, busy, wr_snap);
        end
        run_block(129, 110, 0, 20, 0, 0, lat);
        checks++;
        if (lat !== 140 || nwr !== 129) begin
            failures++; $display("FAIL abort_rerun got lat=%0d wr=%0d exp 140 129", lat, nwr);
        end
        check_129("rerun");
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_single_beat();
        test_saturate();
        test_err();
        test_gap();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
